// File: rtl/axi4lite_arb2.sv
// Two-requester AXI4-Lite arbiter: one transaction in flight at a time, round-robin or
// fixed-priority grant, responses routed back only to the owning requester.
module axi4lite_arb2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // requester 0
    input  logic        inport0_awvalid_i,
    input  logic [31:0] inport0_awaddr_i,
    input  logic        inport0_wvalid_i,
    input  logic [31:0] inport0_wdata_i,
    input  logic [3:0]  inport0_wstrb_i,
    input  logic        inport0_bready_i,
    input  logic        inport0_arvalid_i,
    input  logic [31:0] inport0_araddr_i,
    input  logic        inport0_rready_i,
    output logic        inport0_awready_o,
    output logic        inport0_wready_o,
    output logic        inport0_arready_o,
    output logic        inport0_bvalid_o,
    output logic [1:0]  inport0_bresp_o,
    output logic        inport0_rvalid_o,
    output logic [31:0] inport0_rdata_o,
    output logic [1:0]  inport0_rresp_o,
    // requester 1
    input  logic        inport1_awvalid_i,
    input  logic [31:0] inport1_awaddr_i,
    input  logic        inport1_wvalid_i,
    input  logic [31:0] inport1_wdata_i,
    input  logic [3:0]  inport1_wstrb_i,
    input  logic        inport1_bready_i,
    input  logic        inport1_arvalid_i,
    input  logic [31:0] inport1_araddr_i,
    input  logic        inport1_rready_i,
    output logic        inport1_awready_o,
    output logic        inport1_wready_o,
    output logic        inport1_arready_o,
    output logic        inport1_bvalid_o,
    output logic [1:0]  inport1_bresp_o,
    output logic        inport1_rvalid_o,
    output logic [31:0] inport1_rdata_o,
    output logic [1:0]  inport1_rresp_o,
    // shared downstream port
    input  logic        outport_awready_i,
    input  logic        outport_wready_i,
    input  logic        outport_arready_i,
    input  logic        outport_bvalid_i,
    input  logic [1:0]  outport_bresp_i,
    input  logic        outport_rvalid_i,
    input  logic [31:0] outport_rdata_i,
    input  logic [1:0]  outport_rresp_i,
    output logic        outport_awvalid_o,
    output logic [31:0] outport_awaddr_o,
    output logic        outport_wvalid_o,
    output logic [31:0] outport_wdata_o,
    output logic [3:0]  outport_wstrb_o,
    output logic        outport_bready_o,
    output logic        outport_arvalid_o,
    output logic [31:0] outport_araddr_o,
    output logic        outport_rready_o,
    // debug visibility of the arbiter FSM
    output logic [1:0]  dbg_state_o,
    output logic        dbg_grant_o
);

    // Handshake rule on every channel: a transfer happens on the rising clock edge where
    // valid and ready are both high; a source holds valid and payload until that edge.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;
    logic   ar_done_q, ar_done_d;

    logic        req0, req1;
    logic        sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
    logic [31:0] sel_awaddr, sel_wdata, sel_araddr;
    logic [3:0]  sel_wstrb;

    logic [1:0]  port_awready, port_wready, port_arready, port_bvalid, port_rvalid;
    logic [1:0]  port_bresp [2];
    logic [1:0]  port_rresp [2];
    logic [31:0] port_rdata [2];

    assign req0 = inport0_awvalid_i | inport0_arvalid_i;
    assign req1 = inport1_awvalid_i | inport1_arvalid_i;

    assign sel_awvalid = grant_q ? inport1_awvalid_i : inport0_awvalid_i;
    assign sel_awaddr  = grant_q ? inport1_awaddr_i  : inport0_awaddr_i;
    assign sel_wvalid  = grant_q ? inport1_wvalid_i  : inport0_wvalid_i;
    assign sel_wdata   = grant_q ? inport1_wdata_i   : inport0_wdata_i;
    assign sel_wstrb   = grant_q ? inport1_wstrb_i   : inport0_wstrb_i;
    assign sel_bready  = grant_q ? inport1_bready_i  : inport0_bready_i;
    assign sel_arvalid = grant_q ? inport1_arvalid_i : inport0_arvalid_i;
    assign sel_araddr  = grant_q ? inport1_araddr_i  : inport0_araddr_i;
    assign sel_rready  = grant_q ? inport1_rready_i  : inport0_rready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            ar_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            ar_done_q    <= ar_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        ar_done_d    = ar_done_q;

        outport_awvalid_o = 1'b0;
        outport_awaddr_o  = '0;
        outport_wvalid_o  = 1'b0;
        outport_wdata_o   = '0;
        outport_wstrb_o   = '0;
        outport_bready_o  = 1'b0;
        outport_arvalid_o = 1'b0;
        outport_araddr_o  = '0;
        outport_rready_o  = 1'b0;

        port_awready  = '0;
        port_wready   = '0;
        port_arready  = '0;
        port_bvalid   = '0;
        port_rvalid   = '0;
        port_bresp[0] = '0;
        port_bresp[1] = '0;
        port_rresp[0] = '0;
        port_rresp[1] = '0;
        port_rdata[0] = '0;
        port_rdata[1] = '0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        grant_d = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
                    end else begin
                        grant_d = req1;
                    end
                    // a port presenting both AW and AR is served write-first
                    if (grant_d ? inport1_awvalid_i : inport0_awvalid_i) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end

            ST_WRITE: begin
                outport_awvalid_o     = sel_awvalid & ~aw_done_q;
                outport_awaddr_o      = sel_awaddr;
                outport_wvalid_o      = sel_wvalid & ~w_done_q;
                outport_wdata_o       = sel_wdata;
                outport_wstrb_o       = sel_wstrb;
                port_awready[grant_q] = outport_awready_i & ~aw_done_q;
                port_wready[grant_q]  = outport_wready_i & ~w_done_q;
                if (outport_awvalid_o && outport_awready_i) aw_done_d = 1'b1;
                if (outport_wvalid_o && outport_wready_i)   w_done_d  = 1'b1;
                // B is only meaningful once both request halves have been accepted
                if (aw_done_q && w_done_q) begin
                    outport_bready_o    = sel_bready;
                    port_bvalid[grant_q] = outport_bvalid_i;
                    port_bresp[grant_q]  = outport_bresp_i;
                    if (outport_bvalid_i && sel_bready) begin
                        aw_done_d    = 1'b0;
                        w_done_d     = 1'b0;
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end
                end
            end

            ST_READ: begin
                outport_arvalid_o     = sel_arvalid & ~ar_done_q;
                outport_araddr_o      = sel_araddr;
                port_arready[grant_q] = outport_arready_i & ~ar_done_q;
                if (outport_arvalid_o && outport_arready_i) ar_done_d = 1'b1;
                if (ar_done_q) begin
                    outport_rready_o     = sel_rready;
                    port_rvalid[grant_q] = outport_rvalid_i;
                    port_rdata[grant_q]  = outport_rdata_i;
                    port_rresp[grant_q]  = outport_rresp_i;
                    if (outport_rvalid_i && sel_rready) begin
                        ar_done_d    = 1'b0;
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign inport0_awready_o = port_awready[0];
    assign inport0_wready_o  = port_wready[0];
    assign inport0_arready_o = port_arready[0];
    assign inport0_bvalid_o  = port_bvalid[0];
    assign inport0_bresp_o   = port_bresp[0];
    assign inport0_rvalid_o  = port_rvalid[0];
    assign inport0_rdata_o   = port_rdata[0];
    assign inport0_rresp_o   = port_rresp[0];

    assign inport1_awready_o = port_awready[1];
    assign inport1_wready_o  = port_wready[1];
    assign inport1_arready_o = port_arready[1];
    assign inport1_bvalid_o  = port_bvalid[1];
    assign inport1_bresp_o   = port_bresp[1];
    assign inport1_rvalid_o  = port_rvalid[1];
    assign inport1_rdata_o   = port_rdata[1];
    assign inport1_rresp_o   = port_rresp[1];

    assign dbg_state_o = state_q;
    assign dbg_grant_o = grant_q;

endmodule

// File: doc/axi4lite_arb2.md
Name: axi4lite_arb2

Overview:
Two-requester AXI4-Lite arbiter that shares the peripheral-subsystem slave port between a CPU data port (inport0) and a debug/DMA master (inport1). The output port (outport) connects directly to the peripheral SoC's AXI4-Lite inport. Only one transaction (read or write) is in flight at a time. Arbitration is round-robin or fixed-priority, and responses are routed back to the owning requester.

Parameters:
- FIXED_PRIO, default 0. 0 = round-robin. 1 = inport0 always wins a contested arbitration.

Ports:
Port lists are grouped by channel; N ∈ {0,1}. Every listed signal exists once per N.
- clk_i  input  1  clock
- rst_i  input  1  asynchronous reset, active-low
- inportN_awvalid_i 1, inportN_awaddr_i 32  input  write address from requester N
- inportN_wvalid_i 1, inportN_wdata_i 32, inportN_wstrb_i 4  input  write data
- inportN_bready_i 1, inportN_arvalid_i 1, inportN_araddr_i 32, inportN_rready_i 1  input  B ready, read address, R ready
- inportN_awready_o 1, inportN_wready_o 1, inportN_arready_o 1  output  request-channel readies
- inportN_bvalid_o 1, inportN_bresp_o 2  output  write response
- inportN_rvalid_o 1, inportN_rdata_o 32, inportN_rresp_o 2  output  read response
- outport_awready_i 1, outport_wready_i 1, outport_arready_i 1  input  downstream readies
- outport_bvalid_i 1, outport_bresp_i 2, outport_rvalid_i 1, outport_rdata_i 32, outport_rresp_i 2  input  downstream responses
- outport_awvalid_o 1, outport_awaddr_o 32, outport_wvalid_o 1, outport_wdata_o 32, outport_wstrb_o 4  output  write request
- outport_bready_o 1, outport_arvalid_o 1, outport_araddr_o 32, outport_rready_o 1  output  B ready, read address, R ready

Behaviour:
- **Reset (rst_i low, async):**
  - state=IDLE, grant=0, last_grant=1 (so inport0 wins first), aw_done=w_done=0.
  - All *valid_o and *ready_o outputs are 0. Data outputs are 0.
- **Request definition:** reqN = inportN_awvalid_i | inportN_arvalid_i.
- **Per-port write/read priority:** if a port asserts both awvalid and arvalid, the write is taken first.
- **IDLE:**
  - With no request, stay in IDLE.
  - Only one requester: grant it.
  - Both requesting, FIXED_PRIO=0: grant = ~last_grant.
  - Both requesting, FIXED_PRIO=1: grant = 0.
  - Go to WRITE if the granted port's awvalid is set, else READ.
  - This decision is registered, so there is 1 cycle of arbitration latency. No out-channel is driven in IDLE.
- **WRITE:**
  - outport_awvalid_o = inport[grant]_awvalid_i & ~aw_done.
  - outport_wvalid_o = inport[grant]_wvalid_i & ~w_done.
  - Address, data and strobe pass through combinationally from the granted port.
  - inport[grant]_awready_o = outport_awready_i & ~aw_done; wready likewise.
  - AW and W may complete in either order or in the same cycle; each sets its done flag.
  - B channel passes through to the granted port only, and only once aw_done&w_done. Until then outport_bready_o=0.
  - On outport_bvalid_i & inport[grant]_bready_i: clear the done flags, last_grant=grant, go to IDLE.
- **READ:**
  - outport_arvalid_o = inport[grant]_arvalid_i & ~ar_done.
  - After the AR handshake, R passes through to the granted port.
  - On the rvalid&rready handshake: last_grant=grant, go to IDLE.
- **Ungranted port:** sees all readies and valids at 0 and must hold its request (AXI rule). There is no timeout.
- **Unexpected responses:** a downstream response arriving in IDLE, or a B response in READ (and vice versa), is ignored. Its ready is held at 0.
- **Back-to-back:** minimum of 1 IDLE cycle between transactions. Peak throughput is one transaction per 3 cycles when downstream responds in 1 cycle.
- **Reset mid-transaction:** abandons the transaction immediately and returns to the reset values. Downstream is assumed to be reset by the same rst_i.

Test Plan:
- **Single write:** inport0 writes 0xDEADBEEF to 0x9200_0000, wstrb=0xF, AW and W simultaneous → outport sees identical AW/W exactly 1 cycle later; inport0_bvalid_o with bresp=0; inport1 outputs stay 0.
- **Contention, round-robin:** both ports assert arvalid in the same cycle, repeated 4 times → grant order 0,1,0,1. Each rdata is returned only to its owner.
- **FIXED_PRIO=1:** both ports continuously request → inport0 served every transaction. inport1 is served only when inport0 deasserts.
- **Split write:** W arrives 3 cycles before AW; downstream wready delayed by 2 cycles → single W handshake, no duplicate wvalid after w_done; bvalid forwarded only after both handshakes.
- **Write+read same port:** inport1 asserts awvalid and arvalid together → write completes (B handshake) before AR is forwarded. R holds under rready=0 for 5 cycles without data loss.
- **Reset mid-WRITE:** rst_i driven low after the AW handshake but before B → all outputs 0 asynchronously. After release, inport0 wins first arbitration.
